nibble_add_seq: RTL

Multi-cycle wide adder/subtractor controller that sequences a single 4-bit carry-in adder slice over `NIBBLES` nibbles, LSB nibble first, with a registered carry between steps. It sits between an operand producer and a result consumer. Both sides use valid/ready handshakes. It trades latency for area against a full-width ripple adder. Typical use is 16- or 32-bit arithmetic built from the team's 4-bit adder cells.

---
 rtl/add_seq_pkg.sv | 12 +
 rtl/nibble_add_seq_add4_cin.sv | 21 ++
 rtl/nibble_add_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

endpackage

// File: rtl/nibble_add_seq_add4_cin.sv
// 4-bit ripple-carry adder slice with carry-in, built from full-adder cells.
module add4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// Wide add/sub sequenced one nibble per cycle through a single add4_cin slice.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module nibble_add_seq
    import add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf,
    output add_seq_state_t              dbg_state
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    add_seq_state_t r_state;
    add_seq_state_t w_next;

    logic [W-1:0]        r_opa;
    logic [W-1:0]        r_opb;
    logic [W-1:0]        r_sum;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic [IDX_W-1:0]    r_idx;

    logic [NIBBLE_W-1:0] w_opa_nib;
    logic [NIBBLE_W-1:0] w_opb_nib;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic                w_last;

    assign w_opa_nib = r_opa[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    assign w_opb_nib = r_opb[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    assign w_last    = (r_idx == LAST_IDX);

    add4_cin u_slice (
        .a    (w_opa_nib),
        .b    (w_opb_nib),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B once and seed the carry.
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx)*NIBBLE_W +: NIBBLE_W] <= w_s;
                    r_carry <= w_co;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= (w_opa_nib[NIBBLE_W-1] == w_opb_nib[NIBBLE_W-1]) &
                                  (w_s[NIBBLE_W-1] != w_opa_nib[NIBBLE_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
